// File: rtl/fpu_pack_if.sv
// fpu_pack_if: operand/result handshake bundle for fpu_pack
interface fpu_pack_if #(
  parameter int EXPONENT_WIDTH = 11,
  parameter int SIGNIFICAND_WIDTH = 52
);
  logic                                        in_valid;
  logic                                        in_ready;
  logic                                        in_sign;
  logic signed [EXPONENT_WIDTH+1:0]            in_exponent;
  logic [SIGNIFICAND_WIDTH+4:0]                in_significand;
  logic                                        in_is_nan;
  logic                                        in_is_inf;
  logic                                        in_is_zero;
  logic                                        out_valid;
  logic                                        out_ready;
  logic [EXPONENT_WIDTH+SIGNIFICAND_WIDTH:0]   packed_fp;
  logic                                        overflow;
  logic                                        underflow;
  logic                                        inexact;
  modport master (
    output in_valid, in_sign, in_exponent, in_significand, in_is_nan, in_is_inf, in_is_zero, out_ready,
    input  in_ready, out_valid, packed_fp, overflow, underflow, inexact
  );
  modport slave (
    input  in_valid, in_sign, in_exponent, in_significand, in_is_nan, in_is_inf, in_is_zero, out_ready,
    output in_ready, out_valid, packed_fp, overflow, underflow, inexact
  );
endinterface

// File: rtl/fpu_pack.sv
// fpu_pack: iterative normalize/round-nearest-even/pack to IEEE-754; FPU_PACK_FTZ_EN flushes subnormal results to signed zero
module fpu_pack #(
  parameter int EXPONENT_WIDTH = 11,
  parameter int SIGNIFICAND_WIDTH = 52
) (
  input logic      clk,
  input logic      rst_n,
  fpu_pack_if.slave bus
);
  localparam int E = EXPONENT_WIDTH;
  localparam int S = SIGNIFICAND_WIDTH;
  localparam logic signed [E+1:0] ONE = 1;
  localparam logic signed [E+1:0] MAXE = (1 << E) - 1;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
  state_t state, state_nx;
  logic sign_q, nan_q, inf_q, zero_q, ov_q, uf_q, ix_q;
  logic signed [E+1:0] exp_q, exp_r;
  logic [S+4:0] sig_q;
  logic [E+S:0] pf_q, special_pf, round_pf;
  logic special, exp_lt1, shift_r, shift_l, norm_done;
  logic g, r, st, rup, imp, ix, ovf, tiny;
  logic [S+1:0] sum;
  logic [E-1:0] enc;
  always_comb begin
    special = nan_q | inf_q | zero_q | (sig_q == '0);
    exp_lt1 = exp_q < ONE;
    shift_r = sig_q[S+4] | (exp_lt1 & (sig_q[S+4:1] != '0));
    shift_l = !sig_q[S+3] && exp_q > ONE;
    norm_done = !sig_q[S+4] && !exp_lt1 && !shift_l;
    special_pf = nan_q ? {1'b0, {E{1'b1}}, 1'b1, {(S-1){1'b0}}} :
                 inf_q ? {sign_q, {E{1'b1}}, {S{1'b0}}} : {sign_q, {(E+S){1'b0}}};
    g = sig_q[2];
    r = sig_q[1];
    st = sig_q[0];
    rup = g & (r | st | sig_q[3]);
    sum = {1'b0, sig_q[S+3:3]} + {{(S+1){1'b0}}, rup};
    exp_r = exp_q + {{(E+1){1'b0}}, sum[S+1]};
    imp = sum[S+1] | sum[S];
    ix = g | r | st;
    ovf = exp_r >= MAXE;
    enc = imp ? exp_r[E-1:0] : '0;
`ifdef FPU_PACK_FTZ_EN
    tiny = !imp && !ovf;
`else
    tiny = 1'b0;
`endif
    round_pf = ovf ? {sign_q, {E{1'b1}}, {S{1'b0}}} : tiny ? {sign_q, {(E+S){1'b0}}} : {sign_q, enc, sum[S-1:0]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (bus.in_valid ? NORM : IDLE) :
               state == NORM  ? (special ? OUT : norm_done ? ROUND : NORM) :
               state == ROUND ? OUT : (bus.out_ready ? IDLE : OUT);
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == OUT;
    bus.packed_fp = pf_q;
    bus.overflow = ov_q;
    bus.underflow = uf_q;
    bus.inexact = ix_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign_q <= 1'b0;
      nan_q <= 1'b0;
      inf_q <= 1'b0;
      zero_q <= 1'b0;
      exp_q <= '0;
      sig_q <= '0;
      pf_q <= '0;
      ov_q <= 1'b0;
      uf_q <= 1'b0;
      ix_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      sign_q <= bus.in_sign;
      nan_q <= bus.in_is_nan;
      inf_q <= bus.in_is_inf;
      zero_q <= bus.in_is_zero;
      exp_q <= bus.in_exponent;
      sig_q <= bus.in_significand;
    end else if (state == NORM) begin
      if (special) begin
        pf_q <= special_pf;
        ov_q <= 1'b0;
        uf_q <= 1'b0;
        ix_q <= 1'b0;
      end else if (shift_r) begin
        sig_q <= {1'b0, sig_q[S+4:2], sig_q[1] | sig_q[0]};
        exp_q <= exp_q + ONE;
      end else if (exp_lt1) begin
        exp_q <= ONE;
      end else if (shift_l) begin
        sig_q <= {sig_q[S+3:0], 1'b0};
        exp_q <= exp_q - ONE;
      end
    end else if (state == ROUND) begin
      pf_q <= round_pf;
      ov_q <= ovf;
      uf_q <= tiny | (!ovf & !sig_q[S+3] & ix);
      ix_q <= ovf | tiny | ix;
    end
endmodule

// File: tb/tb_fpu_pack.sv
// tb_fpu_pack: directed vectors for fpu_pack, double precision, checked with immediate assertions
module tb_fpu_pack;
  localparam int E = 11;
  localparam int S = 52;
  localparam logic [S+4:0] IMP = 57'd1 << (S + 3);
  localparam logic [S+4:0] OVB = 57'd1 << (S + 4);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fpu_pack_if #(.EXPONENT_WIDTH(E), .SIGNIFICAND_WIDTH(S)) bus ();
  fpu_pack #(.EXPONENT_WIDTH(E), .SIGNIFICAND_WIDTH(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int lat;
  logic [63:0] pf, held;
  logic ov, uf, ix;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic drive(input logic s, input logic [E+1:0] e, input logic [S+4:0] m, input logic n, input logic i, input logic z);
    @(negedge clk);
    bus.in_sign = s;
    bus.in_exponent = e;
    bus.in_significand = m;
    bus.in_is_nan = n;
    bus.in_is_inf = i;
    bus.in_is_zero = z;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic send(input logic s, input logic [E+1:0] e, input logic [S+4:0] m, input logic n, input logic i, input logic z);
    drive(s, e, m, n, i, z);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
    pf = bus.packed_fp;
    {ov, uf, ix} = {bus.overflow, bus.underflow, bus.inexact};
  endtask
  task automatic drain;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("drained", 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask
  task automatic expect_res(input string tag, input logic [63:0] epf, input logic [2:0] efl, input int elat);
    chk({tag, "_pf"}, pf, epf);
    chk({tag, "_ov_uf_ix"}, 64'({ov, uf, ix}), 64'(efl));
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    drain();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exponent = '0;
    bus.in_significand = '0;
    bus.in_is_nan = 1'b0;
    bus.in_is_inf = 1'b0;
    bus.in_is_zero = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_valid", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("reset_pf", bus.packed_fp, 64'h0);
    chk("reset_flags", 64'({bus.overflow, bus.underflow, bus.inexact}), 64'b000);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 13'd1023, IMP, 1'b0, 1'b0, 1'b0);
    expect_res("one", 64'h3FF0000000000000, 3'b000, 2);
    send(1'b1, 13'd1023, IMP, 1'b0, 1'b0, 1'b0);
    expect_res("minus_one", 64'hBFF0000000000000, 3'b000, 2);
    send(1'b0, 13'd1023, {2'b01, {S{1'b1}}, 3'b100}, 1'b0, 1'b0, 1'b0);
    expect_res("tie_up", 64'h4000000000000000, 3'b001, 2);
    send(1'b0, 13'd1023, IMP | 57'b100, 1'b0, 1'b0, 1'b0);
    expect_res("tie_down", 64'h3FF0000000000000, 3'b001, 2);
    send(1'b0, 13'd2046, OVB, 1'b0, 1'b0, 1'b0);
    expect_res("overflow", 64'h7FF0000000000000, 3'b101, 3);
    send(1'b0, 13'd0, IMP, 1'b0, 1'b0, 1'b0);
`ifdef FPU_PACK_FTZ_EN
    expect_res("subnormal", 64'h0000000000000000, 3'b011, 3);
`else
    expect_res("subnormal", 64'h0008000000000000, 3'b000, 3);
`endif
    send(1'b0, 13'd0, IMP | 57'd1, 1'b0, 1'b0, 1'b0);
`ifdef FPU_PACK_FTZ_EN
    expect_res("subnormal_inexact", 64'h0000000000000000, 3'b011, 3);
`else
    expect_res("subnormal_inexact", 64'h0008000000000000, 3'b011, 3);
`endif
    send(1'b0, 13'd1030, 57'd1 << (S - 1), 1'b0, 1'b0, 1'b0);
    expect_res("left_norm", 64'h4020000000000000, 3'b000, 6);
    send(1'b1, 13'd0, '0, 1'b1, 1'b1, 1'b1);
    expect_res("nan", 64'h7FF8000000000000, 3'b000, 1);
    send(1'b1, 13'd5, IMP, 1'b0, 1'b1, 1'b1);
    expect_res("neg_inf", 64'hFFF0000000000000, 3'b000, 1);
    send(1'b1, 13'd1023, IMP, 1'b0, 1'b0, 1'b1);
    expect_res("neg_zero", 64'h8000000000000000, 3'b000, 1);
    send(1'b0, 13'd1023, '0, 1'b0, 1'b0, 1'b0);
    expect_res("zero_significand", 64'h0000000000000000, 3'b000, 1);
    send(1'b0, 13'd1023, IMP, 1'b0, 1'b0, 1'b0);
    held = pf;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_pf", bus.packed_fp, held);
      chk("stall_ready_valid", 64'({bus.in_ready, bus.out_valid}), 64'b01);
    end
    expect_res("stall", 64'h3FF0000000000000, 3'b000, 2);
    drive(1'b0, 13'd1030, 57'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_norm_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready_valid", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("async_reset_pf", bus.packed_fp, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 13'd1024, IMP, 1'b0, 1'b0, 1'b0);
    expect_res("after_reset", 64'h4000000000000000, 3'b000, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
